// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the multicycle memory bridge.
// State encoding, read-data destination encoding and the reset value of IR.
// No logic lives here; every consumer imports mem_bridge_pkg::*.
package mem_bridge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        DEST_IR  = 1'b0,
        DEST_MDR = 1'b1
    } dest_t;

    // addi x0, x0, 0 -- IR holds this after reset or an aborted fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_bridge_timeout.sv
// Watchdog counting BUSY cycles of one bus transaction.
// expired is combinational in the TIMEOUT_CYCLES-th enabled cycle since clear.
// No backpressure; clear wins over enable.
module mem_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // count BUSY cycles; saturate once the limit is hit so it cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bridge.sv
// Bridge from control-unit memory strobes to one valid/ready bus transaction; fills IR or MDR.
// Latency: 2 cycles minimum (strobe cycle + one BUSY cycle), plus one per bus wait state.
// Backpressure: stall held while a transaction is outstanding; optional abort with MEM_BRIDGE_TIMEOUT_EN.
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memory_read,
    input  logic                  memory_write,
    input  logic                  lorD,
    input  logic                  ir_write,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    input  logic [ADDR_WIDTH-1:0] alu_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  stall,
    output logic                  bus_error,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    dest_t  dest;
    logic   strobe;
    logic   abort;

    assign strobe = memory_read | memory_write;

`ifdef MEM_BRIDGE_TIMEOUT_EN
    logic expired;

    mem_bridge_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .enable (state == BUSY),
        .expired(expired)
    );

    // a completion in the same cycle as expiry takes priority over the abort
    assign abort = expired & ~bus_ready;

    // sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_error <= 1'b0;
        end else if (abort) begin
            bus_error <= 1'b1;
        end
    end
`else
    assign abort     = 1'b0;
    assign bus_error = 1'b0;
`endif

    // freeze the processor from the strobe cycle until the completing (or aborting) cycle
    assign stall = ((state == IDLE) & strobe) |
                   ((state == BUSY) & ~bus_ready & ~abort);

    // transaction FSM: latch request in IDLE, hold the bus in BUSY, capture read data on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dest        <= DEST_MDR;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            instruction <= DATA_WIDTH'(NOP_INSTR);
            mem_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (strobe) begin
                        state     <= BUSY;
                        bus_req   <= 1'b1;
                        // simultaneous read+write is a write; the read is dropped
                        bus_we    <= memory_write;
                        bus_addr  <= lorD ? alu_addr : pc_addr;
                        bus_wdata <= write_data;
                        dest      <= (ir_write & ~memory_write) ? DEST_IR : DEST_MDR;
                    end
                end
                BUSY: begin
                    if (bus_ready) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!bus_we) begin
                            if (dest == DEST_IR) begin
                                instruction <= bus_rdata;
                            end else begin
                                mem_data <= bus_rdata;
                            end
                        end
                    end else if (abort) begin
                        state   <= IDLE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!bus_we) begin
                            if (dest == DEST_IR) begin
                                instruction <= DATA_WIDTH'(NOP_INSTR);
                            end else begin
                                mem_data <= '0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: table of transactions plus reset/idle/timeout sequences.
module tb_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memory_read;
    logic        memory_write;
    logic        lorD;
    logic        ir_write;
    logic [31:0] pc_addr;
    logic [31:0] alu_addr;
    logic [31:0] write_data;
    logic [31:0] instruction;
    logic [31:0] mem_data;
    logic        stall;
    logic        bus_error;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memory_read (memory_read),
        .memory_write(memory_write),
        .lorD        (lorD),
        .ir_write    (ir_write),
        .pc_addr     (pc_addr),
        .alu_addr    (alu_addr),
        .write_data  (write_data),
        .instruction (instruction),
        .mem_data    (mem_data),
        .stall       (stall),
        .bus_error   (bus_error),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        lord;
        logic        irw;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_ir;
        logic [31:0] e_mdr;
        int          e_stalls;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input int idx);
        vec_t v;
        int   stalls;
        logic hold_ok;
        v       = vt[idx];
        stalls  = 0;
        hold_ok = 1'b1;
        memory_read  = v.rd;
        memory_write = v.wr;
        lorD         = v.lord;
        ir_write     = v.irw;
        pc_addr      = v.pc;
        alu_addr     = v.alu;
        write_data   = v.wdata;
        bus_rdata    = v.rdata;
        bus_ready    = 1'b0;
        @(negedge clk);
        if (stall) stalls++;
        @(posedge clk); #1;
        memory_read  = 1'b0;
        memory_write = 1'b0;
        for (int w = 0; w <= v.waits; w++) begin
            bus_ready = (w == v.waits);
            @(negedge clk);
            if (stall) stalls++;
            if (w == 0) begin
                check($sformatf("v%0d bus_addr", idx), bus_addr, v.e_addr);
                check($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.e_we});
            end
            if (!(bus_req === 1'b1 && bus_addr === v.e_addr && bus_we === v.e_we &&
                  bus_wdata === v.wdata))
                hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        check($sformatf("v%0d bus held stable", idx), {31'b0, hold_ok}, 32'd1);
        check($sformatf("v%0d stall cycles", idx), stalls, v.e_stalls);
        check($sformatf("v%0d bus_req dropped", idx), {31'b0, bus_req}, 32'd0);
        check($sformatf("v%0d instruction", idx), instruction, v.e_ir);
        check($sformatf("v%0d mem_data", idx), mem_data, v.e_mdr);
    endtask

    initial begin
        //       rd    wr    lord  irw   pc            alu           wdata         rdata         w  e_addr        e_we  e_ir          e_mdr         stalls
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 32'h0050_0093, 0, 32'h0000_0100, 1'b0, 32'h0050_0093, 32'h0000_0000, 1};
        vt[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_2004, 32'h0000_0000, 32'hCAFE_F00D, 3, 32'h0000_2004, 1'b0, 32'h0050_0093, 32'hCAFE_F00D, 4};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0108, 32'h0000_2008, 32'hDEAD_BEEF, 32'h1111_1111, 2, 32'h0000_2008, 1'b1, 32'h0050_0093, 32'hCAFE_F00D, 3};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_3000, 32'h1234_5678, 32'h5555_5555, 1, 32'h0000_0200, 1'b1, 32'h0050_0093, 32'hCAFE_F00D, 2};
        vt[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0204, 32'h0000_0300, 32'h0000_0000, 32'h00A0_0113, 0, 32'h0000_0300, 1'b0, 32'h00A0_0113, 32'hCAFE_F00D, 1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0040, 32'h0000_0000, 32'h0BAD_F00D, 1, 32'h0000_0040, 1'b0, 32'h0000_0013, 32'h0BAD_F00D, 2};

        rst = 1'b1;
        memory_read = 1'b0; memory_write = 1'b0; lorD = 1'b0; ir_write = 1'b0;
        pc_addr = '0; alu_addr = '0; write_data = '0; bus_ready = 1'b0; bus_rdata = '0;
        #1;
        check("reset instruction", instruction, 32'h0000_0013);
        check("reset mem_data", mem_data, 32'h0);
        check("reset bus_req", {31'b0, bus_req}, 32'd0);
        check("reset bus_we", {31'b0, bus_we}, 32'd0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset stall", {31'b0, stall}, 32'd0);
        check("reset bus_error", {31'b0, bus_error}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // bus_ready while idle must not start or complete anything
        bus_ready = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("idle ready stall", {31'b0, stall}, 32'd0);
            check("idle ready bus_req", {31'b0, bus_req}, 32'd0);
            @(posedge clk); #1;
        end
        bus_ready = 1'b0;
        check("idle ready instruction", instruction, 32'h00A0_0113);
        check("idle ready mem_data", mem_data, 32'hCAFE_F00D);

`ifdef MEM_BRIDGE_TIMEOUT_EN
        begin
            int n_busy;
            int n_stall;
            n_busy  = 0;
            n_stall = 0;
            memory_read = 1'b1; ir_write = 1'b1; lorD = 1'b0; pc_addr = 32'h0000_0400;
            @(posedge clk); #1;
            memory_read = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (!bus_req) break;
                n_busy++;
                if (stall) n_stall++;
            end
            check("timeout busy cycles", n_busy, 8);
            check("timeout stall cycles", n_stall, 7);
            check("timeout bus_error", {31'b0, bus_error}, 32'd1);
            check("timeout instruction NOP", instruction, 32'h0000_0013);
            check("timeout stall released", {31'b0, stall}, 32'd0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("timeout bus_error sticky", {31'b0, bus_error}, 32'd1);
        end
`else
        check("bus_error tied low", {31'b0, bus_error}, 32'd0);
`endif

        // reset in the middle of BUSY
        memory_read = 1'b1; ir_write = 1'b0; lorD = 1'b1; alu_addr = 32'h0000_2040;
        @(posedge clk); #1;
        memory_read = 1'b0;
        @(negedge clk);
        check("midreset busy bus_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("midreset bus_req", {31'b0, bus_req}, 32'd0);
        check("midreset instruction", instruction, 32'h0000_0013);
        check("midreset mem_data", mem_data, 32'h0);
        check("midreset bus_error", {31'b0, bus_error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(5);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
